// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice allocator and its phase-increment ROM.
package synth_pkg;

  localparam int CLK_HZ         = 100_000_000;
  localparam int SAMPLE_HZ      = 48000;
  localparam int INCR_W         = 32;
  localparam int DEF_NUM_VOICES = 4;
  localparam int NUM_NOTES      = 128;
  localparam int NOTE_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_COMMIT
  } state_e;

  // Phase increment for MIDI note n at SAMPLE_HZ: round(f * 2^32 / SAMPLE_HZ), equal temperament, A4 = 440 Hz.
  // Evaluated at elaboration only, so the real arithmetic folds into constants.
  function automatic logic [INCR_W-1:0] note_incr(input int note);
    real freq_hz;
    real incr;
    freq_hz = 440.0 * (2.0 ** ((real'(note) - 69.0) / 12.0));
    incr    = freq_hz * 4294967296.0 / real'(SAMPLE_HZ);
    return INCR_W'(longint'($floor(incr + 0.5)));
  endfunction

endpackage

// File: rtl/note_incr_rom.sv
// 128 x 32 note-to-phase-increment table with a one-cycle registered read.
module note_incr_rom
  import synth_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              en_in,
  input  logic [NOTE_W-1:0] addr_in,
  output logic [INCR_W-1:0] data_out
);

  logic [INCR_W-1:0] table_w [NUM_NOTES];
  logic [INCR_W-1:0] data_d;
  logic [INCR_W-1:0] data_q;

  for (genvar n = 0; n < NUM_NOTES; n++) begin : g_entry
    localparam logic [INCR_W-1:0] ENTRY = note_incr(n);
    assign table_w[n] = ENTRY;
  end

  // Load a new entry only on an accepted event so the value holds for the whole transaction.
  always_comb begin
    // NOTE: default assignment first so every path assigns data_d and no latch is inferred.
    data_d = data_q;
    if (en_in) begin
      data_d = table_w[addr_in];
    end
  end

  // Read register; the table itself is constant logic, so only this register sees reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: only the read register is reset -- the table is elaboration-time constants, not storage.
    if (!rst_n_in) begin
      data_q <= '0;
    end else begin
      // NOTE: non-blocking so every register in the design samples pre-edge values of the others.
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/voice_allocator.sv
// Assigns note events to square-wave voices (retrigger, lowest free, or oldest steal) and makes the sample tick.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                note_valid_in,
  output logic                                note_ready_out,
  input  logic                                note_on_in,
  input  logic [NOTE_W-1:0]                   note_num_in,
  output logic                                step_out,
  output logic [NUM_VOICES-1:0][INCR_W-1:0]   voice_incr_out,
  output logic [NUM_VOICES-1:0]               voice_active_out,
  output logic [NUM_VOICES-1:0]               voice_rst_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] RANK_TOP = IDX_W'(NUM_VOICES - 1);

  typedef logic [IDX_W-1:0] idx_t;

  // Sample-rate divider, free-running and independent of the event FSM.
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: wrap at SAMPLE_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign step_out = (cnt_q == CNT_LAST);

  // Event FSM and voice state.
  state_e                  state_d, state_q;
  logic                    note_on_d, note_on_q;
  logic [NOTE_W-1:0]       note_num_d, note_num_q;
  logic [NUM_VOICES-1:0]   active_d, active_q;
  logic [NUM_VOICES-1:0]   rst_d, rst_q;
  logic [INCR_W-1:0]       incr_d [NUM_VOICES];
  logic [INCR_W-1:0]       incr_q [NUM_VOICES];
  logic [NOTE_W-1:0]       vnote_d [NUM_VOICES];
  logic [NOTE_W-1:0]       vnote_q [NUM_VOICES];
  idx_t                    rank_d [NUM_VOICES];
  idx_t                    rank_q [NUM_VOICES];

  logic                    handshake;
  logic [INCR_W-1:0]       rom_incr;

  assign note_ready_out = (state_q == ST_IDLE);
  assign handshake      = note_valid_in && note_ready_out;

  // Addressed straight from the input so the entry is ready during LOOKUP.
  note_incr_rom u_rom (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en_in    (handshake),
    .addr_in  (note_num_in),
    .data_out (rom_incr)
  );

  logic hit, has_free;
  idx_t hit_idx, free_idx, oldest_idx, sel_idx;

  // Target voice: the active holder of the note, else the lowest free voice, else the oldest (rank 0).
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    has_free   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit && active_q[i] && (vnote_q[i] == note_num_q)) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (!has_free && !active_q[i]) begin
        has_free = 1'b1;
        free_idx = idx_t'(i);
      end
      if (rank_q[i] == '0) begin
        oldest_idx = idx_t'(i);
      end
    end
    sel_idx = hit ? hit_idx : (has_free ? free_idx : oldest_idx);
  end

  // Next-state logic: capture on handshake, wait one cycle for the ROM, apply the event in COMMIT.
  always_comb begin
    state_d    = state_q;
    note_on_d  = note_on_q;
    note_num_d = note_num_q;
    active_d   = active_q;
    rst_d      = '0;
    incr_d     = incr_q;
    vnote_d    = vnote_q;
    rank_d     = rank_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d    = ST_LOOKUP;
          note_on_d  = note_on_in;
          note_num_d = note_num_in;
        end
      end
      ST_LOOKUP: state_d = ST_COMMIT;
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (note_on_q) begin
          // Chosen voice becomes newest; everyone newer than it moves down one rank.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] > rank_q[sel_idx]) rank_d[i] = rank_q[i] - IDX_W'(1);
          end
          rank_d[sel_idx]   = RANK_TOP;
          active_d[sel_idx] = 1'b1;
          rst_d[sel_idx]    = 1'b1;
          incr_d[sel_idx]   = rom_incr;
          vnote_d[sel_idx]  = note_num_q;
        end else if (hit) begin
          active_d[hit_idx] = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, pending event and per-voice registers; reset drops any in-flight event.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      note_on_q  <= 1'b0;
      note_num_q <= '0;
      active_q   <= '0;
      rst_q      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        incr_q[i]  <= '0;
        vnote_q[i] <= '0;
        rank_q[i]  <= idx_t'(i);
      end
    end else begin
      state_q    <= state_d;
      note_on_q  <= note_on_d;
      note_num_q <= note_num_d;
      active_q   <= active_d;
      rst_q      <= rst_d;
      incr_q     <= incr_d;
      vnote_q    <= vnote_d;
      rank_q     <= rank_d;
    end
  end

  // Silent voices present a zero increment.
  always_comb begin
    voice_incr_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_incr_out[i] = active_q[i] ? incr_q[i] : '0;
    end
  end

  assign voice_active_out = active_q;
  assign voice_rst_out    = rst_q;

endmodule
